// File: rtl/running_disparity_checker_if.sv
// Symbol/status bundle between a sub-block encoder and its running-disparity checker.
// The encoder drives the symbol and reads back the RD flag it needs for the next sub-block.
interface running_disparity_checker_if #(
  parameter int BITWIDTH = 6
);
  logic [BITWIDTH-1:0] symbol_i;
  logic                valid_i;
  logic                disparity_o;
  logic                rd_n_o;
  logic signed [4:0]   imbalance_o;
  logic                disp_err_o;

  modport master (
    output symbol_i, valid_i,
    input  disparity_o, rd_n_o, imbalance_o, disp_err_o
  );

  modport slave (
    input  symbol_i, valid_i,
    output disparity_o, rd_n_o, imbalance_o, disp_err_o
  );
endinterface

// File: rtl/running_disparity_checker.sv
// Running-disparity tracker for 3b/4b, 5b/6b and 8b/10b sub-blocks: reports symbol imbalance,
// the post-symbol RD flag (combinational) and registers RD plus a one-cycle violation pulse.
module running_disparity_checker #(
  parameter int BITWIDTH = 6
) (
  input logic                    clk_i,
  input logic                    reset_i,
  running_disparity_checker_if.slave bus
);

  typedef enum logic [1:0] {
    CLS_NEUTRAL,
    CLS_POS,
    CLS_NEG,
    CLS_ILLEGAL
  } sym_class_e;

  // Clamp the unsaturated imbalance into the 5-bit signed output; only +16 at BITWIDTH=16 clips.
  function automatic logic signed [4:0] sat_imb(input logic signed [6:0] x);
    if (x > 7'sd15)       return 5'sd15;
    else if (x < -7'sd16) return -5'sd16;
    else                  return x[4:0];
  endfunction

  logic [4:0]        ones;
  logic signed [6:0] imb_wide;
  sym_class_e        sym_class;
  logic              disparity;
  logic              viol;
  logic              rd_n_q;
  logic              disp_err_q;

  always_comb begin
    ones = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      ones = ones + 5'(bus.symbol_i[i]);
    end
  end

  // Classification uses the unsaturated value so +16 is never mistaken for a legal symbol.
  always_comb begin
    imb_wide = signed'({1'b0, ones, 1'b0}) - 7'(BITWIDTH);
    if (imb_wide == 7'sd2)       sym_class = CLS_POS;
    else if (imb_wide == -7'sd2) sym_class = CLS_NEG;
    else if (imb_wide == 7'sd0)  sym_class = CLS_NEUTRAL;
    else                         sym_class = CLS_ILLEGAL;
  end

  always_comb begin
    disparity = rd_n_q;
    viol      = 1'b0;
    case (sym_class)
      CLS_POS: begin
        disparity = 1'b0;
        viol      = ~rd_n_q;
      end
      CLS_NEG: begin
        disparity = 1'b1;
        viol      = rd_n_q;
      end
      CLS_ILLEGAL: viol = 1'b1;
      default: ;
    endcase
  end

  // Commit stage: RD and the error pulse advance only on valid symbols.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_n_q     <= 1'b1;
      disp_err_q <= 1'b0;
    end else if (bus.valid_i) begin
      rd_n_q     <= disparity;
      disp_err_q <= viol;
    end else begin
      disp_err_q <= 1'b0;
    end
  end

  assign bus.disparity_o = disparity;
  assign bus.imbalance_o = sat_imb(imb_wide);
  assign bus.rd_n_o      = rd_n_q;
  assign bus.disp_err_o  = disp_err_q;

endmodule

// File: tb/tb_running_disparity_checker.sv
// Directed bench for running_disparity_checker: 6-bit vector table, async reset sequence,
// plus 4-bit and 16-bit instances for width and saturation corners.
module tb_running_disparity_checker;

  logic clk = 1'b0;
  logic reset_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  running_disparity_checker_if #(.BITWIDTH(6))  b6 ();
  running_disparity_checker_if #(.BITWIDTH(4))  b4 ();
  running_disparity_checker_if #(.BITWIDTH(16)) b16 ();

  running_disparity_checker #(.BITWIDTH(6))  dut6  (.clk_i(clk), .reset_i(reset_i), .bus(b6));
  running_disparity_checker #(.BITWIDTH(4))  dut4  (.clk_i(clk), .reset_i(reset_i), .bus(b4));
  running_disparity_checker #(.BITWIDTH(16)) dut16 (.clk_i(clk), .reset_i(reset_i), .bus(b16));

  typedef struct {
    logic [5:0]        sym;
    logic              vld;
    logic              exp_disp;
    logic signed [4:0] exp_imb;
    logic              exp_rd;
    logic              exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one 6-bit symbol just after an edge, check comb outputs mid-cycle, registers after the edge.
  task automatic apply6(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    b6.symbol_i = v.sym;
    b6.valid_i  = v.vld;
    #3;
    chk({tag, "_disp"}, int'(b6.disparity_o), int'(v.exp_disp));
    chk({tag, "_imb"},  int'(b6.imbalance_o), int'(v.exp_imb));
    @(posedge clk);
    #1;
    chk({tag, "_rd"},  int'(b6.rd_n_o),     int'(v.exp_rd));
    chk({tag, "_err"}, int'(b6.disp_err_o), int'(v.exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             sym        vld   disp  imb    rd    err
    vecs[0]  = '{6'b100111, 1'b1, 1'b0,  5'sd2, 1'b0, 1'b0};
    vecs[1]  = '{6'b011000, 1'b1, 1'b1, -5'sd2, 1'b1, 1'b0};
    vecs[2]  = '{6'b101010, 1'b1, 1'b1,  5'sd0, 1'b1, 1'b0};
    vecs[3]  = '{6'b000111, 1'b1, 1'b1,  5'sd0, 1'b1, 1'b0};
    vecs[4]  = '{6'b011000, 1'b1, 1'b1, -5'sd2, 1'b1, 1'b1};
    vecs[5]  = '{6'b011000, 1'b0, 1'b1, -5'sd2, 1'b1, 1'b0};
    vecs[6]  = '{6'b100111, 1'b1, 1'b0,  5'sd2, 1'b0, 1'b0};
    vecs[7]  = '{6'b100111, 1'b1, 1'b0,  5'sd2, 1'b0, 1'b1};
    vecs[8]  = '{6'b111000, 1'b1, 1'b0,  5'sd0, 1'b0, 1'b0};
    vecs[9]  = '{6'b111111, 1'b1, 1'b0,  5'sd6, 1'b0, 1'b1};
    vecs[10] = '{6'b111111, 1'b0, 1'b0,  5'sd6, 1'b0, 1'b0};
    vecs[11] = '{6'b000000, 1'b1, 1'b0, -5'sd6, 1'b0, 1'b1};
    vecs[12] = '{6'b000001, 1'b0, 1'b0, -5'sd4, 1'b0, 1'b0};

    reset_i      = 1'b1;
    b6.symbol_i  = '0;
    b6.valid_i   = 1'b0;
    b4.symbol_i  = '0;
    b4.valid_i   = 1'b0;
    b16.symbol_i = '0;
    b16.valid_i  = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_rd",  int'(b6.rd_n_o),     1);
    chk("reset_err", int'(b6.disp_err_o), 0);

    foreach (vecs[i]) apply6(i, vecs[i]);

    // Raise an error pulse with RD+, then reset asynchronously between edges.
    b6.symbol_i = 6'b111111;
    b6.valid_i  = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_err", int'(b6.disp_err_o), 1);
    chk("pre_rst_rd",  int'(b6.rd_n_o),     0);
    b6.valid_i = 1'b0;
    #1;
    reset_i = 1'b1;
    #1;
    chk("async_rst_rd",   int'(b6.rd_n_o),      1);
    chk("async_rst_err",  int'(b6.disp_err_o),  0);
    chk("async_rst_disp", int'(b6.disparity_o), 1);
    #1;
    reset_i     = 1'b0;
    b6.symbol_i = 6'b100111;
    b6.valid_i  = 1'b1;
    #1;
    chk("post_rst_disp", int'(b6.disparity_o), 0);
    @(posedge clk);
    #1;
    chk("post_rst_rd",  int'(b6.rd_n_o),     0);
    chk("post_rst_err", int'(b6.disp_err_o), 0);
    b6.valid_i = 1'b0;

    // 4-bit sub-block: positive commit, then negative against RD+.
    b4.symbol_i = 4'b1011;
    b4.valid_i  = 1'b1;
    #2;
    chk("w4_pos_imb",  int'(b4.imbalance_o), 2);
    chk("w4_pos_disp", int'(b4.disparity_o), 0);
    @(posedge clk);
    #1;
    chk("w4_pos_rd", int'(b4.rd_n_o), 0);
    b4.symbol_i = 4'b0100;
    #2;
    chk("w4_neg_imb",  int'(b4.imbalance_o), -2);
    chk("w4_neg_disp", int'(b4.disparity_o), 1);
    @(posedge clk);
    #1;
    chk("w4_neg_rd",  int'(b4.rd_n_o),     1);
    chk("w4_neg_err", int'(b4.disp_err_o), 0);
    b4.valid_i = 1'b0;

    // 16-bit corners: all-ones saturates at +15 and is illegal; balanced word is neutral.
    b16.symbol_i = 16'hFFFF;
    b16.valid_i  = 1'b1;
    #2;
    chk("w16_sat_imb",  int'(b16.imbalance_o), 15);
    chk("w16_sat_disp", int'(b16.disparity_o), 1);
    @(posedge clk);
    #1;
    chk("w16_sat_err", int'(b16.disp_err_o), 1);
    chk("w16_sat_rd",  int'(b16.rd_n_o),     1);
    b16.symbol_i = 16'h00FF;
    #2;
    chk("w16_neu_imb", int'(b16.imbalance_o), 0);
    @(posedge clk);
    #1;
    chk("w16_neu_err", int'(b16.disp_err_o), 0);
    b16.valid_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
